// File: rtl/gbfwei_pkg.sv
// Shared constants for the GBFWEI weight-buffer controller: default geometry and arbiter state codes.
// Pure definitions, no logic, so there is no latency or backpressure here.
package gbfwei_pkg;

  localparam int GBF_PTR_W = 6;
  localparam int GBF_WIDTH = 28;

  typedef logic [0:0] arb_state_t;

  localparam arb_state_t ARB_RD = 1'b0;
  localparam arb_state_t ARB_WR = 1'b1;

endpackage

// File: rtl/gbfwei_arb.sv
// Single-port arbiter: grants are combinational in the same cycle. Reads win unless GBFWEI_STARVE_GUARD_EN
// lets a fill starved for STARVE_LIM cycles force one write. Grants are withheld during reset and flush.
module gbfwei_arb
  import gbfwei_pkg::*;
`ifdef GBFWEI_STARVE_GUARD_EN
#(
  parameter int STARVE_LIM = 8
)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic fill_valid,
  input  logic rd_req,
  input  logic empty,
  input  logic full,
  output logic fill_ready,
  output logic rd_gnt
);

  arb_state_t state_q;
  arb_state_t state_d;
  logic       go;

  assign go = rst_n & ~flush;

  always_comb begin
    rd_gnt     = 1'b0;
    fill_ready = 1'b0;
    if (state_q == ARB_WR) begin
      fill_ready = go & ~full;
      rd_gnt     = go & rd_req & ~empty & ~fill_valid;
    end else begin
      rd_gnt     = go & rd_req & ~empty;
      fill_ready = go & ~full & ~rd_gnt;
    end
  end

`ifdef GBFWEI_STARVE_GUARD_EN
  localparam int SC_W = (STARVE_LIM > 1) ? $clog2(STARVE_LIM) : 1;

  logic [SC_W-1:0] starve_q;
  logic            wr_fire;
  logic            blocked;

  assign wr_fire = fill_valid & fill_ready;
  assign blocked = fill_valid & ~full & ~fill_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (flush || wr_fire) begin
      starve_q <= '0;
    end else if (blocked) begin
      starve_q <= starve_q + 1'b1;
    end
  end

  // Leave ARB_WR after one write, or as soon as the loader stops offering data.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ARB_RD;
    end else if (state_q == ARB_RD) begin
      if (blocked && (starve_q == SC_W'(STARVE_LIM - 1))) state_d = ARB_WR;
    end else if (wr_fire || !fill_valid) begin
      state_d = ARB_RD;
    end
  end
`else
  assign state_d = ARB_RD;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARB_RD;
    else        state_q <= state_d;
  end

endmodule

// File: rtl/gbfwei_ctrl.sv
// GBFWEI SRAM sequencer: circular FIFO pointers and occupancy around one shared port. Read data returns one cycle
// after rd_gnt. fill_ready drops when full or when a read takes the port. STARVE_LIM exists only with GBFWEI_STARVE_GUARD_EN.
module gbfwei_ctrl
  import gbfwei_pkg::*;
#(
  parameter int SRAM_DEPTH_BIT = GBF_PTR_W,
  parameter int SRAM_WIDTH     = GBF_WIDTH
`ifdef GBFWEI_STARVE_GUARD_EN
  , parameter int STARVE_LIM   = 8
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      fill_valid,
  input  logic [SRAM_WIDTH-1:0]     fill_data,
  output logic                      fill_ready,
  input  logic                      rd_req,
  output logic                      rd_gnt,
  output logic                      rd_valid,
  output logic [SRAM_WIDTH-1:0]     rd_data,
  output logic [SRAM_DEPTH_BIT:0]   count,
  output logic                      empty,
  output logic                      full,
  output logic [SRAM_DEPTH_BIT-1:0] sram_addr_r,
  output logic [SRAM_DEPTH_BIT-1:0] sram_addr_w,
  output logic                      sram_read_en,
  output logic                      sram_write_en,
  output logic [SRAM_WIDTH-1:0]     sram_data_in,
  input  logic [SRAM_WIDTH-1:0]     sram_data_out
);

  localparam int SRAM_DEPTH = 2 ** SRAM_DEPTH_BIT;

  logic rd_vld_q;

  assign empty = (count == '0);
  assign full  = (count == (SRAM_DEPTH_BIT + 1)'(SRAM_DEPTH));

  gbfwei_arb
`ifdef GBFWEI_STARVE_GUARD_EN
    #(.STARVE_LIM(STARVE_LIM))
`endif
  u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .fill_valid (fill_valid),
    .rd_req     (rd_req),
    .empty      (empty),
    .full       (full),
    .fill_ready (fill_ready),
    .rd_gnt     (rd_gnt)
  );

  assign sram_read_en  = rd_gnt;
  assign sram_write_en = fill_valid & fill_ready;
  assign sram_data_in  = fill_data;
  assign rd_data       = sram_data_out;

  // A read issued just before a flush belongs to the discarded contents, so hide its return.
  assign rd_valid = rd_vld_q & ~flush;

  // Pointers are exactly SRAM_DEPTH_BIT wide, so the increment wraps modulo SRAM_DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_addr_r <= '0;
      sram_addr_w <= '0;
      count       <= '0;
      rd_vld_q    <= 1'b0;
    end else if (flush) begin
      sram_addr_r <= '0;
      sram_addr_w <= '0;
      count       <= '0;
      rd_vld_q    <= 1'b0;
    end else begin
      rd_vld_q <= sram_read_en;
      if (sram_write_en) begin
        sram_addr_w <= sram_addr_w + 1'b1;
        count       <= count + 1'b1;
      end else if (sram_read_en) begin
        sram_addr_r <= sram_addr_r + 1'b1;
        count       <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gbfwei_ctrl.sv
// Directed bench for gbfwei_ctrl with a behavioural single-port SRAM behind it.
module tb_gbfwei_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        fill_valid = 1'b0;
  logic        rd_req = 1'b0;
  logic [27:0] fill_data = '0;
  logic        fill_ready, rd_gnt, rd_valid, empty, full;
  logic [27:0] rd_data, sram_data_in;
  logic [27:0] sram_data_out = '0;
  logic [6:0]  count;
  logic [5:0]  sram_addr_r, sram_addr_w;
  logic        sram_read_en, sram_write_en;
  logic [27:0] mem [64];

  int checks = 0;
  int errors = 0;

`ifdef GBFWEI_STARVE_GUARD_EN
  localparam int NR = 8;
`else
  localparam int NR = 10;
`endif

  always #5 clk = ~clk;

  gbfwei_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .fill_valid    (fill_valid),
    .fill_data     (fill_data),
    .fill_ready    (fill_ready),
    .rd_req        (rd_req),
    .rd_gnt        (rd_gnt),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .count         (count),
    .empty         (empty),
    .full          (full),
    .sram_addr_r   (sram_addr_r),
    .sram_addr_w   (sram_addr_w),
    .sram_read_en  (sram_read_en),
    .sram_write_en (sram_write_en),
    .sram_data_in  (sram_data_in),
    .sram_data_out (sram_data_out)
  );

  always @(posedge clk) begin
    if (sram_write_en) mem[sram_addr_w] <= sram_data_in;
    if (sram_read_en)  sram_data_out <= mem[sram_addr_r];
  end

  function automatic logic [27:0] wd(input int i);
    return 28'h05A0000 + 28'(i * 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    // Reset with both requesters active: nothing may be granted.
    #1 rst_n = 1'b0;
    fill_valid = 1'b1;
    rd_req = 1'b1;
    fill_data = wd(0);
    #2;
    chk("rst_fill_ready", fill_ready, 0);
    chk("rst_rd_gnt", rd_gnt, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_addr_r", sram_addr_r, 0);
    chk("rst_addr_w", sram_addr_w, 0);
    chk("rst_read_en", sram_read_en, 0);
    chk("rst_write_en", sram_write_en, 0);
    fill_valid = 1'b0;
    rd_req = 1'b0;
    nxt();
    rst_n = 1'b1;

    // Fill to full with no read pressure.
    for (int i = 0; i < 64; i++) begin
      fill_valid = 1'b1;
      fill_data = wd(i);
      mid();
      chk("fill_ready", fill_ready, 1);
      chk("fill_addr_w", sram_addr_w, i);
      chk("fill_count", count, i);
      if (i < 4) chk("fill_empty", empty, (i == 0));
      nxt();
    end
    fill_data = wd(64);
    mid();
    chk("full_flag", full, 1);
    chk("full_fill_ready", fill_ready, 0);
    chk("full_write_en", sram_write_en, 0);
    chk("full_count", count, 64);
    nxt();
    fill_valid = 1'b0;
    rd_req = 1'b1;
    mid();
    chk("full_rd_gnt", rd_gnt, 1);
    chk("full_addr_r", sram_addr_r, 0);
    nxt();
    rd_req = 1'b0;
    mid();
    chk("after_rd_count", count, 63);
    chk("after_rd_full", full, 0);
    chk("after_rd_valid", rd_valid, 1);
    chk("after_rd_data", rd_data, wd(0));
    nxt();

    // Drain the rest; data must come back in write order.
    rd_req = 1'b1;
    for (int k = 1; k < 64; k++) begin
      mid();
      chk("drain_gnt", rd_gnt, 1);
      if (k > 1) begin
        chk("drain_valid", rd_valid, 1);
        chk("drain_data", rd_data, wd(k - 1));
      end
      nxt();
    end
    mid();
    chk("empty_no_gnt", rd_gnt, 0);
    chk("empty_flag", empty, 1);
    chk("last_valid", rd_valid, 1);
    chk("last_data", rd_data, wd(63));
    nxt();
    mid();
    chk("empty_hold_gnt", rd_gnt, 0);
    chk("empty_hold_valid", rd_valid, 0);
    nxt();

    // Single write with rd_req held: grant next cycle, data the cycle after.
    fill_valid = 1'b1;
    fill_data = wd(100);
    mid();
    chk("wr1_fill_ready", fill_ready, 1);
    chk("wr1_rd_gnt", rd_gnt, 0);
    nxt();
    fill_valid = 1'b0;
    mid();
    chk("wr1_then_gnt", rd_gnt, 1);
    chk("wr1_not_empty", empty, 0);
    nxt();
    rd_req = 1'b0;
    mid();
    chk("wr1_rd_valid", rd_valid, 1);
    chk("wr1_rd_data", rd_data, wd(100));
    nxt();

    // Contention with count=10: reads win until the guard (if built) forces one write.
    for (int i = 0; i < 10; i++) begin
      fill_valid = 1'b1;
      fill_data = wd(200 + i);
      nxt();
    end
    fill_data = wd(300);
    rd_req = 1'b1;
    for (int c = 0; c < NR + 2; c++) begin
      mid();
      chk("arb_rd_gnt", rd_gnt, (c != NR));
      chk("arb_fill_ready", fill_ready, (c == NR));
      chk("arb_excl", sram_read_en & sram_write_en, 0);
      nxt();
    end
    rd_req = 1'b0;

    // Read granted, then flush in the following cycle.
    for (int i = 0; i < 3; i++) begin
      fill_valid = 1'b1;
      fill_data = wd(350 + i);
      nxt();
    end
    fill_valid = 1'b0;
    rd_req = 1'b1;
    mid();
    chk("pre_flush_gnt", rd_gnt, 1);
    nxt();
    flush = 1'b1;
    mid();
    chk("flush_rd_valid", rd_valid, 0);
    chk("flush_rd_gnt", rd_gnt, 0);
    chk("flush_fill_ready", fill_ready, 0);
    nxt();
    flush = 1'b0;
    rd_req = 1'b0;
    mid();
    chk("post_flush_valid", rd_valid, 0);
    chk("post_flush_count", count, 0);
    chk("post_flush_empty", empty, 1);
    chk("post_flush_addr_r", sram_addr_r, 0);
    chk("post_flush_addr_w", sram_addr_w, 0);
    nxt();

    // 70 interleaved write/read pairs: addresses wrap 63 -> 0, order preserved.
    for (int i = 0; i < 70; i++) begin
      fill_valid = 1'b1;
      rd_req = 1'b0;
      fill_data = wd(400 + i);
      mid();
      chk("wrap_write_en", sram_write_en, 1);
      chk("wrap_addr_w", sram_addr_w, i % 64);
      if (i > 0) begin
        chk("wrap_valid", rd_valid, 1);
        chk("wrap_data", rd_data, wd(400 + i - 1));
      end
      nxt();
      fill_valid = 1'b0;
      rd_req = 1'b1;
      mid();
      chk("wrap_gnt", rd_gnt, 1);
      chk("wrap_addr_r", sram_addr_r, i % 64);
      chk("wrap_count", count, 1);
      nxt();
    end
    rd_req = 1'b0;
    mid();
    chk("wrap_last_valid", rd_valid, 1);
    chk("wrap_last_data", rd_data, wd(469));
    chk("wrap_count_end", count, 0);
    nxt();

    // Reset during an outstanding read return.
    for (int i = 0; i < 2; i++) begin
      fill_valid = 1'b1;
      fill_data = wd(500 + i);
      nxt();
    end
    fill_valid = 1'b0;
    rd_req = 1'b1;
    nxt();
    rd_req = 1'b0;
    mid();
    chk("mid_rst_pre_valid", rd_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rd_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_addr_w", sram_addr_w, 0);
    chk("mid_rst_addr_r", sram_addr_r, 0);
    nxt();
    rst_n = 1'b1;
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
